// File: rtl/spi_reg_ctrl.sv
// Register-access sequencer for a byte-wide SPI master: frames each transaction
// with chip select, sends a command byte then a data byte, and returns read data.
module spi_reg_ctrl #(
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic       done,
    output logic       rvalid,
    output logic [7:0] rdata,
    output logic       cs_n,
    output logic       spi_start,
    output logic [7:0] spi_data_in,
    input  logic       spi_busy,
    input  logic       spi_new_data,
    input  logic [7:0] spi_data_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CMD, S_CMD_WAIT, S_DATA, S_DATA_WAIT, S_HOLD
    } state_t;

    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic       r_rw;
    logic [6:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_cs_n;
    logic       r_done;
    logic       r_rvalid;
    logic [7:0] r_rdata;
    logic       w_start;
    logic [7:0] w_data_in;
    logic [7:0] w_cmd_byte;
    logic [7:0] w_data_byte;

    assign w_cmd_byte  = {r_rw, r_addr};
    assign w_data_byte = r_rw ? 8'h00 : r_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // spi_start and spi_data_in are decoded from state so the start pulse lands
    // in the same cycle spi_busy is seen low, and the byte stays up until the
    // matching byte-complete pulse.
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_data_in = 8'h00;
        case (r_state)
            S_IDLE:  if (req) w_next = S_SETUP;
            S_SETUP: if (r_cnt == SETUP_LAST) w_next = S_CMD;
            S_CMD: begin
                if (!spi_busy) begin
                    w_start   = 1'b1;
                    w_data_in = w_cmd_byte;
                    w_next    = S_CMD_WAIT;
                end
            end
            S_CMD_WAIT: begin
                w_data_in = w_cmd_byte;
                if (spi_new_data) w_next = S_DATA;
            end
            S_DATA: begin
                if (!spi_busy) begin
                    w_start   = 1'b1;
                    w_data_in = w_data_byte;
                    w_next    = S_DATA_WAIT;
                end
            end
            S_DATA_WAIT: begin
                w_data_in = w_data_byte;
                if (spi_new_data) w_next = S_HOLD;
            end
            S_HOLD:  if (r_cnt == HOLD_LAST) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= 8'h00;
            r_rw     <= 1'b0;
            r_addr   <= 7'h00;
            r_wdata  <= 8'h00;
            r_cs_n   <= 1'b1;
            r_done   <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= 8'h00;
        end else begin
            r_done   <= 1'b0;
            r_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_rw    <= rw;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_cs_n  <= 1'b0;
                        r_cnt   <= 8'h00;
                    end
                end
                S_SETUP: r_cnt <= r_cnt + 8'h01;
                S_DATA_WAIT: begin
                    if (spi_new_data) begin
                        if (r_rw) r_rdata <= spi_data_out;
                        r_cnt <= 8'h00;
                    end
                end
                S_HOLD: begin
                    r_cnt <= r_cnt + 8'h01;
                    if (r_cnt == HOLD_LAST) begin
                        r_cs_n   <= 1'b1;
                        r_done   <= 1'b1;
                        r_rvalid <= r_rw;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready       = (r_state == S_IDLE);
    assign done        = r_done;
    assign rvalid      = r_rvalid;
    assign rdata       = r_rdata;
    assign cs_n        = r_cs_n;
    assign spi_start   = w_start;
    assign spi_data_in = w_data_in;

endmodule
